// File: rtl/cajero_controlador_pkg.sv
// Shared types and sizing for the ATM transaction controller.
// Imported by the interface, the PIN checker and the top level.
package cajero_pkg;

  localparam int N_DIGITOS    = 4;
  localparam int MAX_INTENTOS = 3;
  localparam int BALANCE_W    = 64;
  localparam int MONTO_W      = 32;

  typedef enum logic [2:0] {
    ESPERA_TARJETA,
    INGRESO_PIN,
    ESPERA_MONTO,
    FIN,
    BLOQUEO
  } estado_t;

endpackage

// File: rtl/cajero_controlador_if.sv
// Card/PIN/amount stimulus bus between the tester (master) and the controller (slave).
interface cajero_controlador_if;
  import cajero_pkg::*;

  logic                 tarjeta_recibida;
  logic                 tipo_tarjeta;
  logic [15:0]          pin;
  logic [3:0]           digito;
  logic                 digito_stb;
  logic                 tipo_transaccion;
  logic [MONTO_W-1:0]   monto;
  logic                 monto_stb;
  logic [BALANCE_W-1:0] balance;
  logic                 balance_actualizado;
  logic                 entregar_dinero;
  logic                 fondos_insuficientes;
  logic                 pin_incorrecto;
  logic                 advertencia;
  logic                 bloqueo;

  modport master (
    output tarjeta_recibida, tipo_tarjeta, pin, digito, digito_stb,
           tipo_transaccion, monto, monto_stb,
    input  balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
           pin_incorrecto, advertencia, bloqueo
  );

  modport slave (
    input  tarjeta_recibida, tipo_tarjeta, pin, digito, digito_stb,
           tipo_transaccion, monto, monto_stb,
    output balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
           pin_incorrecto, advertencia, bloqueo
  );

endinterface

// File: rtl/cajero_controlador_pin_verificador.sv
// Collects PIN digits MSB-first and flags the strobe that completes a 4-digit entry.
// Only the first three digits are stored; the fourth is compared straight off the input.
module pin_verificador
  import cajero_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        limpiar,
  input  logic        digito_stb,
  input  logic [3:0]  digito,
  input  logic [15:0] pin_ref,
  output logic        pin_listo,
  output logic        pin_ok
);

  logic [11:0] digitos;
  logic [1:0]  cuenta;

  // The count wraps to zero on the completing digit, so a mismatch restarts entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digitos <= '0;
      cuenta  <= '0;
    end else if (limpiar) begin
      digitos <= '0;
      cuenta  <= '0;
    end else if (digito_stb) begin
      digitos <= {digitos[7:0], digito};
      cuenta  <= cuenta + 2'd1;
    end
  end

  assign pin_listo = digito_stb && !limpiar && (cuenta == 2'(N_DIGITOS - 1));
  assign pin_ok    = ({digitos, digito} == pin_ref);

endmodule

// File: rtl/cajero_controlador.sv
// ATM transaction controller: card session FSM, PIN attempt tracking and balance update.
module cajero_controlador
  import cajero_pkg::*;
#(
  parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = 64'd50000,
  parameter logic [MONTO_W-1:0]   COMISION        = 32'd0
) (
  input  logic                clk,
  input  logic                rst,
  cajero_controlador_if.slave bus
);

  estado_t              estado, estado_n;
  logic [1:0]           intentos, intentos_n;
  logic [15:0]          pin_l, pin_n;
  logic                 tipo_l, tipo_n;
  logic [BALANCE_W-1:0] balance_q, balance_n;
  logic                 act_q, act_n, entregar_q, entregar_n;
  logic                 fondos_q, fondos_n, inc_q, inc_n;
  logic                 adv_q, adv_n, bloq_q, bloq_n;

  logic                 limpiar, stb_pin, pin_listo, pin_ok;
  logic [BALANCE_W:0]   suma;
  logic [BALANCE_W-1:0] deposito;
  logic [MONTO_W:0]     costo;
  logic [BALANCE_W-1:0] costo_ext;

  // Removal wins over a same-edge digit strobe, so the count is cleared instead.
  assign limpiar = (estado != INGRESO_PIN) || !bus.tarjeta_recibida;
  assign stb_pin = bus.digito_stb && (estado == INGRESO_PIN);

  pin_verificador u_pin (
    .clk        (clk),
    .rst        (rst),
    .limpiar    (limpiar),
    .digito_stb (stb_pin),
    .digito     (bus.digito),
    .pin_ref    (pin_l),
    .pin_listo  (pin_listo),
    .pin_ok     (pin_ok)
  );

  assign suma      = {1'b0, balance_q} + (BALANCE_W + 1)'(bus.monto);
  assign deposito  = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
  assign costo     = {1'b0, bus.monto} + (tipo_l ? {1'b0, COMISION} : '0);
  assign costo_ext = BALANCE_W'(costo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado     <= ESPERA_TARJETA;
      intentos   <= '0;
      pin_l      <= '0;
      tipo_l     <= 1'b0;
      balance_q  <= BALANCE_INICIAL;
      act_q      <= 1'b0;
      entregar_q <= 1'b0;
      fondos_q   <= 1'b0;
      inc_q      <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
    end else begin
      estado     <= estado_n;
      intentos   <= intentos_n;
      pin_l      <= pin_n;
      tipo_l     <= tipo_n;
      balance_q  <= balance_n;
      act_q      <= act_n;
      entregar_q <= entregar_n;
      fondos_q   <= fondos_n;
      inc_q      <= inc_n;
      adv_q      <= adv_n;
      bloq_q     <= bloq_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    intentos_n = intentos;
    pin_n      = pin_l;
    tipo_n     = tipo_l;
    balance_n  = balance_q;
    adv_n      = adv_q;
    bloq_n     = bloq_q;
    act_n      = 1'b0;
    entregar_n = 1'b0;
    fondos_n   = 1'b0;
    inc_n      = 1'b0;
    case (estado)
      ESPERA_TARJETA: begin
        if (bus.tarjeta_recibida) begin
          pin_n    = bus.pin;
          tipo_n   = bus.tipo_tarjeta;
          estado_n = INGRESO_PIN;
        end
      end
      INGRESO_PIN: begin
        if (!bus.tarjeta_recibida) begin
          estado_n   = ESPERA_TARJETA;
          intentos_n = '0;
          adv_n      = 1'b0;
        end else if (pin_listo) begin
          if (pin_ok) begin
            intentos_n = '0;
            adv_n      = 1'b0;
            estado_n   = ESPERA_MONTO;
          end else begin
            inc_n = 1'b1;
            if (intentos == 2'(MAX_INTENTOS - 1)) begin
              bloq_n   = 1'b1;
              estado_n = BLOQUEO;
            end else begin
              intentos_n = intentos + 2'd1;
              if (intentos == 2'(MAX_INTENTOS - 2)) adv_n = 1'b1;
            end
          end
        end
      end
      ESPERA_MONTO: begin
        if (!bus.tarjeta_recibida) begin
          estado_n   = ESPERA_TARJETA;
          intentos_n = '0;
          adv_n      = 1'b0;
        end else if (bus.monto_stb) begin
          if (!bus.tipo_transaccion) begin
            balance_n = deposito;
            act_n     = 1'b1;
            estado_n  = FIN;
          end else if (costo_ext <= balance_q) begin
            balance_n  = balance_q - costo_ext;
            act_n      = 1'b1;
            entregar_n = 1'b1;
            estado_n   = FIN;
          end else begin
            fondos_n = 1'b1;
          end
        end
      end
      FIN: begin
        if (!bus.tarjeta_recibida) estado_n = ESPERA_TARJETA;
      end
      BLOQUEO: ;
      default: estado_n = ESPERA_TARJETA;
    endcase
  end

  assign bus.balance              = balance_q;
  assign bus.balance_actualizado  = act_q;
  assign bus.entregar_dinero      = entregar_q;
  assign bus.fondos_insuficientes = fondos_q;
  assign bus.pin_incorrecto       = inc_q;
  assign bus.advertencia          = adv_q;
  assign bus.bloqueo              = bloq_q;

endmodule

// File: tb/tb_cajero_controlador.sv
// Directed bench: one stimulus stream drives a zero-fee and a 100-fee controller side by side.
module tb_cajero_controlador;
  import cajero_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cajero_controlador_if bus0 ();
  cajero_controlador_if bus1 ();

  cajero_controlador #(.BALANCE_INICIAL(64'd50000), .COMISION(32'd0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cajero_controlador #(.BALANCE_INICIAL(64'd50000), .COMISION(32'd100))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  logic        card = 1'b0;
  logic        tipo = 1'b0;
  logic [15:0] pinv = 16'h6953;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus on both buses, inputs set at the falling edge, sampled 1ns after rising.
  task automatic applyStimulus(input logic dstb, input logic [3:0] d, input logic mstb,
                               input logic tx, input logic [31:0] m);
    @(negedge clk);
    bus0.tarjeta_recibida = card; bus1.tarjeta_recibida = card;
    bus0.tipo_tarjeta = tipo;     bus1.tipo_tarjeta = tipo;
    bus0.pin = pinv;              bus1.pin = pinv;
    bus0.digito_stb = dstb;       bus1.digito_stb = dstb;
    bus0.digito = d;              bus1.digito = d;
    bus0.monto_stb = mstb;        bus1.monto_stb = mstb;
    bus0.tipo_transaccion = tx;   bus1.tipo_transaccion = tx;
    bus0.monto = m;               bus1.monto = m;
    @(posedge clk);
    #1;
    bus0.digito_stb = 1'b0; bus1.digito_stb = 1'b0;
    bus0.monto_stb = 1'b0;  bus1.monto_stb = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic digit(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic enterPin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) digit(p[i*4 +: 4]);
  endtask

  task automatic amount(input logic tx, input logic [31:0] m);
    applyStimulus(1'b0, 4'd0, 1'b1, tx, m);
  endtask

  initial begin
    bus0.tarjeta_recibida = 0; bus0.tipo_tarjeta = 0; bus0.pin = 0; bus0.digito = 0;
    bus0.digito_stb = 0; bus0.tipo_transaccion = 0; bus0.monto = 0; bus0.monto_stb = 0;
    bus1.tarjeta_recibida = 0; bus1.tipo_tarjeta = 0; bus1.pin = 0; bus1.digito = 0;
    bus1.digito_stb = 0; bus1.tipo_transaccion = 0; bus1.monto = 0; bus1.monto_stb = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_balance", bus0.balance, 64'd50000);
    checkOutput("reset_bloqueo", 64'(bus0.bloqueo), 64'd0);
    checkOutput("reset_advertencia", 64'(bus0.advertencia), 64'd0);
    checkOutput("reset_pulses", 64'({bus0.balance_actualizado, bus0.entregar_dinero,
                bus0.fondos_insuficientes, bus0.pin_incorrecto}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Own-bank deposit
    card = 1'b1; tipo = 1'b0; idle();
    enterPin(16'h6953);
    checkOutput("t1_pin_ok", 64'(bus0.pin_incorrecto), 64'd0);
    amount(1'b0, 32'd30000);
    checkOutput("t1_actualizado", 64'(bus0.balance_actualizado), 64'd1);
    checkOutput("t1_balance", bus0.balance, 64'd80000);
    checkOutput("t1_no_entregar", 64'(bus0.entregar_dinero), 64'd0);
    card = 1'b0; idle();
    checkOutput("t1_pulse_end", 64'(bus0.balance_actualizado), 64'd0);

    // One wrong PIN then a withdrawal with other-bank card
    card = 1'b1; tipo = 1'b1; idle();
    enterPin(16'h1953);
    checkOutput("t2_incorrecto", 64'(bus0.pin_incorrecto), 64'd1);
    checkOutput("t2_no_adv", 64'(bus0.advertencia), 64'd0);
    digit(4'd6);
    checkOutput("t2_inc_one_cycle", 64'(bus0.pin_incorrecto), 64'd0);
    digit(4'd9); digit(4'd5); digit(4'd3);
    checkOutput("t2_pin_ok", 64'(bus0.pin_incorrecto), 64'd0);
    amount(1'b1, 32'd4520);
    checkOutput("t2_entregar", 64'(bus0.entregar_dinero), 64'd1);
    checkOutput("t2_actualizado", 64'(bus0.balance_actualizado), 64'd1);
    checkOutput("t2_balance", bus0.balance, 64'd75480);
    checkOutput("t2_balance_fee", bus1.balance, 64'd75380);
    card = 1'b0; idle();

    // Warning after second mismatch, insufficient funds, then a good withdrawal
    card = 1'b1; idle();
    enterPin(16'h1111);
    checkOutput("t3_adv_first", 64'(bus0.advertencia), 64'd0);
    enterPin(16'h2222);
    checkOutput("t3_inc_second", 64'(bus0.pin_incorrecto), 64'd1);
    checkOutput("t3_adv_second", 64'(bus0.advertencia), 64'd1);
    enterPin(16'h6953);
    checkOutput("t3_adv_cleared", 64'(bus0.advertencia), 64'd0);
    amount(1'b1, 32'd90000);
    checkOutput("t3_fondos", 64'(bus0.fondos_insuficientes), 64'd1);
    checkOutput("t3_no_act", 64'(bus0.balance_actualizado), 64'd0);
    checkOutput("t3_balance_kept", bus0.balance, 64'd75480);
    amount(1'b1, 32'd3000);
    checkOutput("t3_entregar", 64'(bus0.entregar_dinero), 64'd1);
    checkOutput("t3_balance", bus0.balance, 64'd72480);
    card = 1'b0; idle();

    // Three mismatches block the controller until reset
    card = 1'b1; idle();
    enterPin(16'h1111);
    enterPin(16'h2222);
    enterPin(16'h3333);
    checkOutput("t4_inc_third", 64'(bus0.pin_incorrecto), 64'd1);
    checkOutput("t4_bloqueo", 64'(bus0.bloqueo), 64'd1);
    checkOutput("t4_adv_blocked", 64'(bus0.advertencia), 64'd1);
    enterPin(16'h6953);
    checkOutput("t4_digits_ignored", 64'(bus0.pin_incorrecto), 64'd0);
    amount(1'b0, 32'd1000);
    checkOutput("t4_monto_ignored", 64'(bus0.balance_actualizado), 64'd0);
    checkOutput("t4_balance_kept", bus0.balance, 64'd72480);
    card = 1'b0; idle();
    checkOutput("t4_still_blocked", 64'(bus0.bloqueo), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("t4_reset_bloqueo", 64'(bus0.bloqueo), 64'd0);
    checkOutput("t4_reset_balance", bus0.balance, 64'd50000);
    checkOutput("t4_reset_adv", 64'(bus0.advertencia), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fee boundary: 49950+100 exceeds 50000, 49900+100 empties the account
    card = 1'b1; tipo = 1'b1; idle();
    enterPin(16'h6953);
    amount(1'b1, 32'd49950);
    checkOutput("t5_fee_fondos", 64'(bus1.fondos_insuficientes), 64'd1);
    checkOutput("t5_fee_balance_kept", bus1.balance, 64'd50000);
    checkOutput("t5_nofee_balance", bus0.balance, 64'd50);
    amount(1'b1, 32'd49900);
    checkOutput("t5_fee_entregar", 64'(bus1.entregar_dinero), 64'd1);
    checkOutput("t5_fee_balance_zero", bus1.balance, 64'd0);
    checkOutput("t5_fin_ignores_monto", 64'(bus0.balance_actualizado), 64'd0);
    checkOutput("t5_fin_balance", bus0.balance, 64'd50);
    card = 1'b0; idle();

    // Removal mid-entry clears attempts and warning; removal wins over a same-edge strobe
    card = 1'b1; idle();
    enterPin(16'h1111);
    enterPin(16'h2222);
    checkOutput("t6_adv_set", 64'(bus0.advertencia), 64'd1);
    digit(4'd6); digit(4'd9);
    card = 1'b0; idle();
    checkOutput("t6_adv_cleared", 64'(bus0.advertencia), 64'd0);
    card = 1'b1; idle();
    digit(4'd6); digit(4'd9);
    checkOutput("t6_no_early_result", 64'(bus0.pin_incorrecto), 64'd0);
    digit(4'd5); digit(4'd3);
    checkOutput("t6_fresh_pin_ok", 64'(bus0.pin_incorrecto), 64'd0);
    amount(1'b0, 32'd0);
    checkOutput("t6_zero_deposit_act", 64'(bus0.balance_actualizado), 64'd1);
    checkOutput("t6_zero_deposit_bal", bus0.balance, 64'd50);
    card = 1'b0; idle();
    card = 1'b1; idle();
    enterPin(16'h6953);
    card = 1'b0;
    amount(1'b0, 32'd500);
    checkOutput("t6_removal_wins_act", 64'(bus0.balance_actualizado), 64'd0);
    checkOutput("t6_removal_wins_bal", bus0.balance, 64'd50);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/cajero_controlador.md
# cajero_controlador

ATM transaction controller: the responder end of the card/PIN/amount stimulus interface driven by `cajero_tester`. It accepts card insertion, collects and checks a 4-digit PIN entered one strobe at a time, and processes one deposit or withdrawal against an internal account balance. It reports results through single-cycle result pulses and level status flags. Blocking after three wrong PINs is sticky until reset.

## Interface
- `BALANCE_INICIAL`, default 64'd50000: balance loaded at reset.
- `COMISION`, default 32'd0: fee added to withdrawals when `tipo_tarjeta`=1 (other bank).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tarjeta_recibida`  in  1  card present (level).
- `tipo_tarjeta`  in  1  0 = own bank (BCR), 1 = other bank.
- `pin`  in  16  stored PIN, 4 BCD nibbles, `[15:12]` first digit.
- `digito`  in  4  entered digit.
- `digito_stb`  in  1  digit valid; one digit captured per high cycle.
- `tipo_transaccion`  in  1  0 = deposit, 1 = withdrawal.
- `monto`  in  32  amount.
- `monto_stb`  in  1  amount valid, one cycle.
- `balance`  out  64  current balance.
- `balance_actualizado`  out  1  pulse: transaction applied.
- `entregar_dinero`  out  1  pulse: dispense cash (withdrawal only).
- `fondos_insuficientes`  out  1  pulse: withdrawal rejected.
- `pin_incorrecto`  out  1  pulse: wrong PIN.
- `advertencia`  out  1  level: one attempt left.
- `bloqueo`  out  1  level: blocked.

## Operation
- States: ESPERA_TARJETA, INGRESO_PIN, ESPERA_MONTO, FIN, BLOQUEO.
- ESPERA_TARJETA: on `tarjeta_recibida`=1, latch `pin` and `tipo_tarjeta`, clear the digit count, and go to INGRESO_PIN.
- INGRESO_PIN:
  - Each `digito_stb` cycle shifts `digito` into a 16-bit register, MSB nibble first, and increments the 2-bit count.
  - On the 4th digit, compare the 4 digits with the latched PIN.
  - Match: clear `intentos`, drop `advertencia`, go to ESPERA_MONTO.
  - Mismatch with `intentos`=0: pulse `pin_incorrecto`, set `intentos`=1.
  - Mismatch with `intentos`=1: pulse `pin_incorrecto`, set `advertencia`, set `intentos`=2.
  - Mismatch with `intentos`=2: pulse `pin_incorrecto`, set `bloqueo`, go to BLOQUEO.
  - Every mismatch restarts digit collection.
- ESPERA_MONTO, on `monto_stb`:
  - Deposit: add `monto` to `balance`, saturating at 2^64−1. Pulse `balance_actualizado`, go to FIN.
  - Withdrawal: cost = `monto` + (`tipo_tarjeta` ? `COMISION` : 0), computed 33-bit and zero-extended.
    - cost ≤ `balance`: subtract cost, pulse `balance_actualizado` and `entregar_dinero`, go to FIN.
    - cost > `balance`: pulse `fondos_insuficientes`, leave `balance` unchanged, stay in ESPERA_MONTO.
  - `monto`=0 is a valid transaction.
- FIN: ignore strobes; on `tarjeta_recibida`=0 go to ESPERA_TARJETA.
- BLOQUEO: absorbing; all inputs ignored; only `rst` exits.
- Card removal in INGRESO_PIN or ESPERA_MONTO: go to ESPERA_TARJETA, clear `intentos`, digit count and `advertencia`. `balance` is untouched.
- Strobes in ESPERA_TARJETA are ignored. `monto_stb` in INGRESO_PIN and `digito_stb` in ESPERA_MONTO are ignored.

## Timing
- Reset (`rst`=0): state ESPERA_TARJETA, `balance`=`BALANCE_INICIAL`, `intentos`=0, all pulses and flags 0. Effect is immediate and asynchronous, including mid-transaction; a pending operation is discarded.
- All outputs are registered.
- Result latency:
  - PIN result appears on the clock edge that captures the 4th digit.
  - Transaction result appears on the edge that samples `monto_stb`.
  - Both are visible for exactly one cycle after that edge.
- Card sampling: `pin` and `tipo_tarjeta` are sampled on the edge where `tarjeta_recibida` is first seen high in ESPERA_TARJETA. The first digit may arrive on the next edge.
- Card removal: if `tarjeta_recibida` falls on the same edge as a strobe, removal wins and the strobe is discarded.
- `advertencia` stays high from the 2nd mismatch until a match, card removal, or reset. It also stays high while blocked.

## Structure
- Package `cajero_pkg`:
  - state enum `estado_t`
  - `N_DIGITOS`=4, `MAX_INTENTOS`=3
  - `BALANCE_W`=64, `MONTO_W`=32
- Sub-module `pin_verificador`: digit shift register, count, compare.
  - Outputs `pin_listo` and `pin_ok`.
  - Cleared by `rst` or by a `limpiar` input.
- Top level holds the FSM, attempt counter, and balance arithmetic.

## Test plan
- Card with PIN 16'h6953, `tipo_tarjeta`=0; digits 6,9,5,3; deposit 30000 → one-cycle `balance_actualizado`, `balance`=80000, no `entregar_dinero`.
- PIN 1,9,5,3 then 6,9,5,3; withdraw 4520, `tipo_tarjeta`=1, `COMISION`=0 → `pin_incorrecto` pulse once, no `advertencia`, then `entregar_dinero` + `balance_actualizado`, `balance`=75480.
- Two wrong PINs then correct; withdraw 90000 → `advertencia` high after the 2nd mismatch, cleared on match. 90000 → `fondos_insuficientes`, balance unchanged. Then withdraw 3000 → `balance`=72480.
- Three wrong PINs → third mismatch raises `bloqueo`; later strobes have no effect. `rst` low → `bloqueo`=0, `balance`=50000.
- `COMISION`=100, `tipo_tarjeta`=1, `balance`=50000: withdraw 49950 → `fondos_insuficientes`; withdraw 49900 → `balance`=0.
- Card removed after 2 digits, then reinserted → fresh 4-digit entry required, `intentos`=0; removal in FIN returns to ESPERA_TARJETA.
